// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM clock controller.
// Time is kept in binary; to_bcd2 splits a 0..99 value into two BCD digits.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    localparam int unsigned HOURS_MOD = 24;
    localparam int unsigned MIN_MOD   = 60;
    localparam int unsigned SEC_MOD   = 60;

    typedef logic [3:0] bcd_t;

    // Repeated subtraction keeps this a small adder chain instead of a divider.
    function automatic logic [7:0] to_bcd2(input logic [6:0] v);
        logic [6:0] r;
        bcd_t       t;
        r = v;
        t = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            // Any cycle where the synchronised input agrees with the level restarts the count.
            if (s2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                    press <= s2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// HH:MM:SS timekeeper with MODE/INC set-mode FSM and INC auto-repeat.
// Drives registered BCD digits, blink selects and decimal points for the mux.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 100000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 20000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] dd,
    output logic       sa,
    output logic       sb,
    output logic       sc,
    output logic       sd
);

    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic mode_press;
    logic inc_level;
    logic inc_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode),
        .level (),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    mode_t         mode;
    logic [PW-1:0] presc;
    logic [5:0]    secs;
    logic [5:0]    mins;
    logic [4:0]    hrs;

    logic          rep_active;
    logic          rep_started;
    logic [RW-1:0] rep_cnt;

    logic          tick;
    logic          rep_live;
    logic          rep_pulse;
    logic          inc_evt;
    logic [RW-1:0] rep_target;

    // rep_cnt holds the number of cycles since the press (or since the last repeat).
    always_comb begin
        tick       = (mode == RUN) && (presc == PW'(TICK_DIV - 1));
        rep_target = rep_started ? RW'(REPEAT_CYCLES) : RW'(HOLD_CYCLES);
        rep_live   = rep_active && inc_level && (mode != RUN);
        rep_pulse  = rep_live && (rep_cnt == rep_target);
        inc_evt    = (inc_press || rep_pulse) && (mode != RUN) && !mode_press;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_active  <= 1'b0;
            rep_started <= 1'b0;
            rep_cnt     <= '0;
        end else if (inc_press && (mode != RUN)) begin
            rep_active  <= 1'b1;
            rep_started <= 1'b0;
            rep_cnt     <= RW'(1);
        end else if (!rep_live) begin
            rep_active  <= 1'b0;
            rep_started <= 1'b0;
            rep_cnt     <= '0;
        end else if (rep_pulse) begin
            rep_started <= 1'b1;
            rep_cnt     <= RW'(1);
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    // A mode press takes priority: it swallows both a coincident tick and an inc event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode  <= RUN;
            presc <= '0;
            secs  <= '0;
            mins  <= '0;
            hrs   <= '0;
        end else if (mode_press) begin
            case (mode)
                RUN:     mode <= SET_HR;
                SET_HR:  mode <= SET_MIN;
                SET_MIN: begin
                    mode  <= RUN;
                    secs  <= '0;
                    presc <= '0;
                end
                default: mode <= RUN;
            endcase
        end else if (mode == RUN) begin
            if (tick) begin
                presc <= '0;
                if (secs == 6'(SEC_MOD - 1)) begin
                    secs <= '0;
                    if (mins == 6'(MIN_MOD - 1)) begin
                        mins <= '0;
                        hrs  <= (hrs == 5'(HOURS_MOD - 1)) ? '0 : hrs + 5'd1;
                    end else begin
                        mins <= mins + 6'd1;
                    end
                end else begin
                    secs <= secs + 6'd1;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end else if (inc_evt) begin
            if (mode == SET_HR) begin
                hrs <= (hrs == 5'(HOURS_MOD - 1)) ? '0 : hrs + 5'd1;
            end else begin
                mins <= (mins == 6'(MIN_MOD - 1)) ? '0 : mins + 6'd1;
            end
        end
    end

    logic [7:0] hr_bcd;
    logic [7:0] min_bcd;
    logic       sep;

    always_comb begin
        hr_bcd  = to_bcd2({2'b00, hrs});
        min_bcd = to_bcd2({1'b0, mins});
        sep     = (mode != RUN) || (presc < PW'(TICK_DIV / 2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a  <= '0;
            b  <= '0;
            c  <= '0;
            d  <= '0;
            dd <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            sc <= 1'b0;
            sd <= 1'b0;
        end else begin
            a  <= hr_bcd[7:4];
            b  <= hr_bcd[3:0];
            c  <= min_bcd[7:4];
            d  <= min_bcd[3:0];
            dd <= {2'b00, sep, 1'b0};
            sa <= (mode == SET_HR);
            sb <= (mode == SET_HR);
            sc <= (mode == SET_MIN);
            sd <= (mode == SET_MIN);
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed button sequences plus random button traffic,
// every cycle compared against a behavioural model of the clock.
module tb_clock_ctrl;

    localparam int TICK = 10;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] a, b, c, d, dd;
    logic       sa, sb, sc, sd;
    logic [23:0] dut_out;

    int n_cmp = 0;
    int n_bad = 0;

    clock_ctrl #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .dd       (dd),
        .sa       (sa),
        .sb       (sb),
        .sc       (sc),
        .sd       (sd)
    );

    always #5 clk = ~clk;

    assign dut_out = {a, b, c, d, dd, sa, sb, sc, sd};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=RUN 1=SET_HR 2=SET_MIN, time as plain integers.
    int          m_mode, m_presc, m_sec, m_min, m_hr;
    int          cyc = 0;
    int          m_pcyc;
    bit          m_armed;
    bit          m_s1[2], m_s2[2], m_lvl[2], m_prs[2];
    logic [DEB-1:0] m_win[2];
    logic [23:0] m_out = '0;

    task automatic model_edge(input bit rm, input bit ri, input bit rst);
        logic [23:0] nout;
        logic [3:0]  s;
        bit          mp, ip, ilvl, rep, inc, flip, raw;
        int          k, t;
        cyc++;
        if (!rst) begin
            m_mode = 0; m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0;
            m_armed = 0; m_pcyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prs[i] = 0; m_win[i] = '0;
            end
            m_out = '0;
            return;
        end
        s = (m_mode == 1) ? 4'b1100 : (m_mode == 2) ? 4'b0011 : 4'b0000;
        nout = {4'(m_hr / 10), 4'(m_hr % 10), 4'(m_min / 10), 4'(m_min % 10),
                2'b00, (m_mode != 0) || (m_presc < TICK / 2), 1'b0, s};

        mp = m_prs[0];
        ip = m_prs[1];
        ilvl = m_lvl[1];
        if (m_armed && (!ilvl || m_mode == 0)) m_armed = 0;
        k = cyc - m_pcyc;
        rep = m_armed && (k == HOLD || (k > HOLD && ((k - HOLD) % REP) == 0));
        if (ip && m_mode != 0) begin
            m_armed = 1;
            m_pcyc = cyc;
        end
        inc = (ip || rep) && (m_mode != 0) && !mp;

        if (mp) begin
            if (m_mode == 2) begin
                m_sec = 0;
                m_presc = 0;
            end
            m_mode = (m_mode + 1) % 3;
        end else if (m_mode == 0) begin
            if (m_presc == TICK - 1) begin
                m_presc = 0;
                t = (m_hr * 3600 + m_min * 60 + m_sec + 1) % 86400;
                m_hr = t / 3600;
                m_min = (t / 60) % 60;
                m_sec = t % 60;
            end else begin
                m_presc++;
            end
        end else if (inc) begin
            if (m_mode == 1) m_hr = (m_hr + 1) % 24;
            else             m_min = (m_min + 1) % 60;
        end

        // Debounced level flips once the last DEB synchronised samples all disagree with it.
        for (int i = 0; i < 2; i++) begin
            raw = (i == 0) ? rm : ri;
            m_win[i] = {m_win[i][DEB-2:0], m_s2[i]};
            flip = m_lvl[i] ? (m_win[i] == '0) : (m_win[i] == '1);
            m_prs[i] = flip && !m_lvl[i];
            if (flip) m_lvl[i] = !m_lvl[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw;
        end
        m_out = nout;
    endtask

    task automatic step(input bit rm, input bit ri);
        btn_mode = rm;
        btn_inc  = ri;
        @(posedge clk);
        model_edge(rm, ri, rst_n);
        #1;
        check_eq("outs", dut_out, m_out);
    endtask

    task automatic hold(input bit rm, input bit ri, input int n);
        for (int i = 0; i < n; i++) step(rm, ri);
    endtask

    task automatic press_inc();
        hold(0, 1, 8);
        hold(0, 0, 8);
    endtask

    task automatic press_mode();
        hold(1, 0, 8);
        hold(0, 0, 8);
    endtask

    initial begin
        int len;
        bit rm, ri;

        rst_n = 1'b0;
        hold(0, 0, 3);
        check_eq("reset_zero", dut_out, 24'h0);
        rst_n = 1'b1;

        hold(0, 0, 6005);
        check_eq("run_0010", dut_out[23:8], 16'h0010);
        check_eq("run_blink", dut_out[3:0], 4'h0);

        // Bouncy MODE press: only the final stable high should register.
        hold(1, 0, 2);
        hold(0, 0, 2);
        hold(1, 0, 3);
        hold(0, 0, 1);
        hold(1, 0, 10);
        hold(0, 0, 10);
        check_eq("sethr_blink", dut_out[3:0], 4'b1100);
        check_eq("sethr_dot", dut_out[7:4], 4'b0010);

        for (int i = 0; i < 25; i++) press_inc();
        check_eq("hr_wrap_01", dut_out[23:8], 16'h0110);

        press_mode();
        check_eq("setmin_blink", dut_out[3:0], 4'b0011);
        for (int i = 0; i < 49; i++) press_inc();
        check_eq("min_59", dut_out[23:8], 16'h0159);
        press_inc();
        check_eq("min_wrap", dut_out[23:8], 16'h0100);
        hold(0, 1, 40);
        hold(0, 0, 12);
        check_eq("auto_repeat", dut_out[23:8], 16'h0105);

        press_mode();
        press_mode();
        for (int i = 0; i < 22; i++) press_inc();
        press_mode();
        for (int i = 0; i < 54; i++) press_inc();
        press_mode();
        hold(0, 0, 300);
        check_eq("pre_roll", dut_out[23:8], 16'h2359);
        hold(0, 0, 400);
        check_eq("rollover", dut_out[23:8], 16'h0000);

        press_mode();
        hold(1, 1, 8);
        hold(0, 0, 8);
        check_eq("mode_wins", dut_out, 24'h000023);

        hold(0, 1, 15);
        rst_n = 1'b0;
        step(0, 1);
        check_eq("reset_mid", dut_out, 24'h0);
        rst_n = 1'b1;
        hold(0, 1, 30);
        hold(0, 0, 10);
        check_eq("post_rst_run", dut_out[3:0], 4'h0);
        check_eq("post_rst_time", dut_out[23:8], 16'h0000);

        for (int seg = 0; seg < 300; seg++) begin
            rm  = ($urandom_range(0, 3) == 0);
            ri  = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                step(rm, ri);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                hold(rm, ri, $urandom_range(1, 3));
                hold(!rm, !ri, $urandom_range(1, 3));
            end
            hold(rm, ri, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Timekeeping and user-setting controller for the 4-digit HH:MM clock display. It counts seconds, minutes and hours from the system clock, and debounces the MODE and INC buttons. A 3-state set-mode FSM runs from those buttons. The block drives the display multiplexer's BCD digits, per-digit blink selects and decimal points, and owns all time state while the multiplexer only renders.

Parameters:
TICK_DIV, 100000000, clk cycles per second (≥2, even)
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button must be stable before the debounced level changes
HOLD_CYCLES, 50000000, cycles INC must stay held before auto-repeat starts
REPEAT_CYCLES, 20000000, auto-repeat period once started

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
btn_mode  in  1  raw asynchronous MODE button, active-high
btn_inc  in  1  raw asynchronous INC button, active-high
a  out  4  BCD tens of hours (leftmost digit)
b  out  4  BCD units of hours
c  out  4  BCD tens of minutes
d  out  4  BCD units of minutes (rightmost)
dd  out  4  decimal points; dd[i] is the dot for digit a,b,c,d (i=0..3), 1 = lit
sa, sb, sc, sd  out  1 each  blink enable for digits a..d

Behaviour:
- Reset (rst_n=0 at a posedge): time = 00:00:00, prescaler = 0, mode = RUN, debouncers cleared (level 0, counters 0), repeat logic idle. Outputs: a=b=c=d=0, dd=0, all s* = 0. Reset mid-anything overrides all else.
- Buttons: 2-FF synchroniser. A debounced level flips only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. A press is a 1-cycle pulse on the debounced rising edge.
- Auto-repeat (INC only, SET modes only): held level for HOLD_CYCLES after its press pulse → extra inc pulse, then one every REPEAT_CYCLES while held. Release or leaving SET cancels it.
- Prescaler: counts 0..TICK_DIV-1 in RUN; tick pulse on wrap. A tick increments seconds 0..59. Seconds wrap carries to minutes 0..59, which carries to hours 0..23. 23:59:59 + tick → 00:00:00.
- FSM states: RUN, SET_HR, SET_MIN. A mode press moves RUN→SET_HR→SET_MIN→RUN.
  - Entering SET_HR: prescaler and seconds are held (not counting).
  - Leaving SET_MIN to RUN: seconds := 0, prescaler := 0.
- INC in SET_HR: hours := (hours+1) mod 24. INC in SET_MIN: minutes := (minutes+1) mod 60, with no carry to hours. INC in RUN: ignored.
- Simultaneous events:
  - Mode press and inc pulse in the same cycle: mode wins, inc dropped.
  - Tick coinciding with a mode press from RUN: tick discarded.
- Time is stored as BCD or binary with conversion (implementer's choice). Output digits are always valid BCD, 0..9.
- Output latency: outputs are registered one cycle after internal state. A press pulse at cycle N updates state at N+1 and outputs at N+2.
- Blink selects:
  - RUN: all 0.
  - SET_HR: sa=sb=1.
  - SET_MIN: sc=sd=1.
- dd[1] (hour/minute separator):
  - RUN: 1 while prescaler < TICK_DIV/2, else 0.
  - SET modes: steady 1.
- dd[0], dd[2], dd[3] are always 0.

Decomposition:
- Package clock_pkg holds:
  - mode enum {RUN, SET_HR, SET_MIN} (2 bits)
  - constants HOURS_MOD=24, MIN_MOD=60, SEC_MOD=60
  - BCD digit type (4 bits)
- Sub-module btn_debounce (synchroniser, stability counter, rising-edge pulse, param DEBOUNCE_CYCLES) is instantiated twice. Auto-repeat stays in clock_ctrl.

Test Plan:
Bench parameters: TICK_DIV=10, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
1. Reset, then run 600 ticks (6000 cycles) → a,b,c,d = 0,0,1,0 (00:10). dd[1] is 1 for prescaler 0..4 and 0 for 5..9; all s* = 0.
2. Bounce btn_mode 1,0,1 with each level held <4 cycles, then hold 1 → exactly one mode press, and only after the final 4 stable cycles. sa=sb=1 two cycles later; dd[1]=1 steady.
3. In SET_HR from 22:xx, issue 3 INC presses → hours 23, 00, 01. a,b = 0,1; minutes unchanged.
4. In SET_MIN at 59, one INC → c,d = 0,0 and hours unchanged. Hold INC for 40 cycles → one press plus auto-repeats at hold cycles 20, 25, 30, 35 → minutes = 5.
5. Preload 23:59:59 in RUN, one tick → 00:00:00. Assert mode and inc pulses in the same cycle → mode advances, time unchanged.
6. Assert rst_n=0 mid SET_MIN with INC held → next cycle all outputs zero and mode RUN. After release, no spurious press until a new debounced rising edge.
